// File: rtl/oc8051_alu_src_pipe.sv
// Queued ALU operand source selector: buffers decoded operand sets, resolves them against live ACC/RAM/PC/DPTR at issue.
// Optional same-edge bypass of an empty queue: define OC8051_ALU_SRC_BYPASS_EN.
module oc8051_alu_src_pipe #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              op1,
    input  logic [DW-1:0]              op2,
    input  logic [DW-1:0]              op3,
    input  logic [2:0]                 sel1,
    input  logic [1:0]                 sel2,
    input  logic                       sel3,
    input  logic [DW-1:0]              acc,
    input  logic [DW-1:0]              ram,
    input  logic [2*DW-1:0]            pc,
    input  logic [2*DW-1:0]            dptr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              src1,
    output logic [DW-1:0]              src2,
    output logic [DW-1:0]              src3,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 3 * DW + 6;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] src1_q, src1_d;
    logic [DW-1:0] src2_q, src2_d;
    logic [DW-1:0] src3_q, src3_d;

    logic          can_load, queue_empty, load, bypass, push_fifo;
    logic [EW-1:0] entry_in, head, chosen;
    logic [DW-1:0] c_op1, c_op2, c_op3;
    logic [2:0]    c_sel1;
    logic [1:0]    c_sel2;
    logic          c_sel3;

    // Low byte of DPTR is never a source.
    logic unused_dptr_lo;
    assign unused_dptr_lo = ^dptr[DW-1:0];

    function automatic logic [DW-1:0] mux_src1(input logic [2:0] s, input logic [DW-1:0] o1,
                                               input logic [DW-1:0] o2, input logic [DW-1:0] o3,
                                               input logic [DW-1:0] a, input logic [DW-1:0] r,
                                               input logic [2*DW-1:0] p);
        logic [DW-1:0] v;
        case (s)
            3'b000:  v = r;
            3'b001:  v = a;
            3'b010:  v = o1;
            3'b011:  v = o2;
            3'b100:  v = o3;
            3'b101:  v = p[2*DW-1:DW];
            3'b110:  v = p[DW-1:0];
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [DW-1:0] mux_src2(input logic [1:0] s, input logic [DW-1:0] o2,
                                               input logic [DW-1:0] a, input logic [DW-1:0] r);
        logic [DW-1:0] v;
        case (s)
            2'b00:   v = a;
            2'b01:   v = '0;
            2'b10:   v = r;
            default: v = o2;
        endcase
        return v;
    endfunction

    assign entry_in = {op1, op2, op3, sel1, sel2, sel3};
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        in_ready    = (count_q != CW'(DEPTH)) & rst;
        can_load    = ~out_valid_q | out_ready;
        queue_empty = (count_q == '0);
        load        = ~queue_empty & can_load;
`ifdef OC8051_ALU_SRC_BYPASS_EN
        bypass      = queue_empty & in_valid & can_load;
`else
        bypass      = 1'b0;
`endif
        push_fifo   = in_valid & in_ready & ~bypass;

        // Bypass only happens with an empty queue, so load and bypass never coincide.
        chosen = bypass ? entry_in : head;
        {c_op1, c_op2, c_op3, c_sel1, c_sel2, c_sel3} = chosen;

        wr_ptr_d    = wr_ptr_q + AW'(push_fifo);
        rd_ptr_d    = rd_ptr_q + AW'(load);
        count_d     = count_q + CW'(push_fifo) - CW'(load);

        src1_d      = src1_q;
        src2_d      = src2_q;
        src3_d      = src3_q;
        out_valid_d = out_valid_q;
        if (load | bypass) begin
            src1_d      = mux_src1(c_sel1, c_op1, c_op2, c_op3, acc, ram, pc);
            src2_d      = mux_src2(c_sel2, c_op2, acc, ram);
            src3_d      = c_sel3 ? pc[2*DW-1:DW] : dptr[2*DW-1:DW];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fifo) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            src3_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            src3_q      <= src3_d;
        end
    end

    assign out_valid = out_valid_q;
    assign src1      = src1_q;
    assign src2      = src2_q;
    assign src3      = src3_q;
    assign count     = count_q;

endmodule

// File: tb/tb_oc8051_alu_src_pipe.sv
// Randomized + directed bench for oc8051_alu_src_pipe against a queue-based reference model.
module tb_oc8051_alu_src_pipe;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef OC8051_ALU_SRC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [7:0] o1, o2, o3;
        logic [2:0] s1;
        logic [1:0] s2;
        logic       s3;
    } set_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, sel3;
    logic [7:0] op1, op2, op3, acc, ram, src1, src2, src3;
    logic [2:0] sel1;
    logic [1:0] sel2;
    logic [15:0] pc, dptr;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    set_t mq[$];
    logic       mv;
    logic [7:0] m1, m2, m3;

    logic [7:0] exp_s1 [8] = '{8'h5A, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h12, 8'h34, 8'h00};
    logic [7:0] exp_s2 [4] = '{8'hA5, 8'h00, 8'h5A, 8'h22};
    logic [7:0] exp_s3 [2] = '{8'hAB, 8'h12};

    always #5 clk = ~clk;

    oc8051_alu_src_pipe #(.DW(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .op3(op3), .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .acc(acc), .ram(ram), .pc(pc), .dptr(dptr),
        .out_valid(out_valid), .out_ready(out_ready),
        .src1(src1), .src2(src2), .src3(src3), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference model: a plain FIFO of operand sets plus one output slot, resolved by the select tables.
    function automatic logic [7:0] res1(input set_t s);
        case (s.s1)
            3'd0: return ram;
            3'd1: return acc;
            3'd2: return s.o1;
            3'd3: return s.o2;
            3'd4: return s.o3;
            3'd5: return pc[15:8];
            3'd6: return pc[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] res2(input set_t s);
        case (s.s2)
            2'd0: return acc;
            2'd1: return 8'h00;
            2'd2: return ram;
            default: return s.o2;
        endcase
    endfunction

    task automatic issue(input set_t s);
        m1 = res1(s);
        m2 = res2(s);
        m3 = s.s3 ? pc[15:8] : dptr[15:8];
        mv = 1'b1;
    endtask

    // Advance one clock: update the model from the inputs seen at this edge, then compare after the edge.
    task automatic tick();
        set_t cur, hd;
        bit can, byp, psh;
        cur = '{o1: op1, o2: op2, o3: op3, s1: sel1, s2: sel2, s3: sel3};
        if (mv && out_ready && rst)
            $display("xfer src1=%02h src2=%02h src3=%02h", m1, m2, m3);
        if (!rst) begin
            mq.delete();
            mv = 1'b0; m1 = '0; m2 = '0; m3 = '0;
        end else begin
            can = !mv || out_ready;
            byp = BYP && mq.size() == 0 && in_valid && can;
            psh = in_valid && mq.size() != DEPTH && !byp;
            if (mq.size() != 0 && can) begin
                hd = mq.pop_front();
                issue(hd);
            end else if (byp) begin
                issue(cur);
            end else if (out_ready) begin
                mv = 1'b0;
            end
            if (psh) mq.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", out_valid, mv);
        chk("count", count, mq.size());
        chk("in_ready", in_ready, rst && mq.size() != DEPTH);
        chk("src1", src1, m1);
        chk("src2", src2, m2);
        chk("src3", src3, m3);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = 8'h11; op2 = 8'h22; op3 = 8'h33; sel1 = '0; sel2 = '0; sel3 = 1'b0;
        acc = 8'hA5; ram = 8'h5A; pc = 16'h1234; dptr = 16'hABCD;
        mv = 1'b0; m1 = '0; m2 = '0; m3 = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Select tables
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int n;
            in_valid = 1'b1;
            sel1 = 3'(k); sel2 = 2'(k % 4); sel3 = 1'(k % 2);
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 4) begin tick(); n++; end
            chk("sel_wait", out_valid, 1);
            chk("sel1_tab", src1, exp_s1[k]);
            chk("sel2_tab", src2, exp_s2[k % 4]);
            chk("sel3_tab", src3, exp_s3[k % 2]);
            tick();
        end

        // Backpressure fill and ordered drain
        drain();
        out_ready = 1'b0;
        sel1 = 3'd2;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1;
            op1 = 8'h40 + 8'(i);
            tick();
        end
        chk("bp_count", count, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", src1, 8'h40);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold", src1, 8'h40);
        end
        out_ready = 1'b1;
        for (int e = 0; e <= DEPTH; e++) begin
            chk("order_valid", out_valid, 1);
            chk("order", src1, 8'h40 + 8'(e));
            tick();
        end
        chk("order_end", out_valid, 0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            op1 = 8'($urandom); op2 = 8'($urandom); op3 = 8'($urandom);
            sel1 = 3'($urandom); sel2 = 2'($urandom); sel3 = 1'($urandom);
            tick();
            chk("stream_cnt", count <= 1, 1);
        end
        chk("stream_valid", out_valid, 1);

        // Live sampling
        drain();
        in_valid = 1'b1; sel1 = 3'd1; acc = 8'h10;
        tick();
        in_valid = 1'b0; acc = 8'h20;
        tick();
        chk("live_acc", src1, BYP ? 8'h10 : 8'h20);

        // Latency
        drain();
        in_valid = 1'b1;
        tick();
        chk("lat1_valid", out_valid, BYP);
        chk("lat1_count", count, BYP ? 0 : 1);
        in_valid = 1'b0;
        tick();
        chk("lat2_valid", out_valid, BYP ? 0 : 1);

        // Reset mid-stream
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op1 = 8'h70 + 8'(i); sel1 = 3'($urandom);
            tick();
        end
        chk("pre_rst_count", count, 2);
        chk("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0; rst = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_srcs", {src1, src2, src3}, 0);
        rst = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", out_valid, 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            in_valid = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            op1 = 8'($urandom); op2 = 8'($urandom); op3 = 8'($urandom);
            sel1 = 3'($urandom); sel2 = 2'($urandom); sel3 = 1'($urandom);
            acc = 8'($urandom); ram = 8'($urandom);
            pc = 16'($urandom); dptr = 16'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/oc8051_alu_src_pipe.md
# oc8051_alu_src_pipe

Parametrised, pipelined successor to the 8051 ALU operand source selector. It accepts decoded instruction operand bytes and source-select codes through a valid/ready handshake and buffers them in a DEPTH-entry queue. At issue time it resolves three ALU sources against live ACC/RAM/PC/DPTR and presents them in a registered output stage with its own valid/ready handshake. It sits between the decoder/operand fetch and the ALU, so the decoder can run ahead of ALU stalls.

## Interface
Parameters:
- DW, 8, data width of operands, ACC, RAM and sources
- DEPTH, 2, operand queue entries; power of 2, range 2..8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operand set offered
- in_ready  out  1  queue can accept
- op1, op2, op3  in  DW each  instruction operand bytes
- sel1  in  3  src1 select code
- sel2  in  2  src2 select code
- sel3  in  1  src3 select code
- acc, ram  in  DW each  live accumulator / RAM read data
- pc, dptr  in  2*DW each  live program counter / data pointer
- out_valid  out  1  src1..src3 hold a valid set
- out_ready  in  1  ALU consumes the set
- src1, src2, src3  out  DW each  registered ALU sources
- count  out  $clog2(DEPTH+1)  entries currently queued, excluding the output stage

## Operation
- Push: in_valid & in_ready stores {op1,op2,op3,sel1,sel2,sel3} at the write pointer. Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH) & rst. It does not depend on out_ready, so there is no push while full.
- Output load condition: queue non-empty & (!out_valid | out_ready). On load, head is popped and src regs are written from the head entry plus live acc/ram/pc/dptr sampled at that edge.
- sel1: 000 ram, 001 acc, 010 op1, 011 op2, 100 op3, 101 pc[2DW-1:DW], 110 pc[DW-1:0], 111 zero. Code 111 is always defined.
- sel2: 00 acc, 01 zero, 10 ram, 11 op2.
- sel3: 0 dptr[2DW-1:DW], 1 pc[2DW-1:DW].
- out_valid clears when out_ready is high and no load occurs in the same cycle.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push while empty: the entry is not visible to a load until the next edge, unless bypass is enabled (see Configuration).
- Reset low at an edge: pointers, count, out_valid and src1..3 are cleared. Queued and in-flight sets are discarded, and nothing is emitted for them.

## Timing
- Reset values: out_valid 0, src1/src2/src3 0, count 0, in_ready 0 while rst is low and 1 from the first cycle after release.
- Latency, bypass off: push at edge N, then out_valid=1 and srcs valid after edge N+1.
- Live inputs are sampled at the load edge, not the push edge.
- Throughput: one set per cycle sustained when out_ready is held high and DEPTH ≥ 2.
- Output held stable while out_valid & !out_ready.

## Configuration
- OC8051_ALU_SRC_BYPASS_EN defined: bypass is taken when the queue is empty & in_valid & (!out_valid | out_ready). In that case, the input set is resolved directly into the src regs at the push edge (latency 1), and the queue and count are untouched.
- OC8051_ALU_SRC_BYPASS_EN undefined: every set passes through the queue, with latency 2 as above.

## Test plan
- Reset: drive rst=0 mid-stream with 2 entries queued and out_valid=1 → next cycle count=0, out_valid=0, src1..3=0, and no stale set appears after release.
- Select coverage: for each sel1 code with op1=11, op2=22, op3=33, acc=A5, ram=5A, pc=1234 → src1 = 5A, A5, 11, 22, 33, 12, 34, 00 respectively. Check sel2 and sel3 likewise (dptr=ABCD → sel3=0 gives AB).
- Backpressure fill: hold out_ready=0 and push DEPTH+1 sets → count reaches DEPTH, in_ready drops, and the output holds the first set stably. Then assert out_ready → sets emerge in push order.
- Streaming: out_ready=1 and in_valid=1 for 20 cycles → one set out per cycle, count ≤ 1, and no losses or duplicates.
- Live sampling: push with sel1=001 while acc=10, change acc to 20 before the load edge → src1=20.
- Latency: with the queue empty, push one set → out_valid rises after 2 edges without OC8051_ALU_SRC_BYPASS_EN and after 1 edge with it. count stays 0 in the bypass case.
